// File: rtl/gbt_rx_frameclk_phalgnr_pkg.sv
// Shared types and constants for the RX frame-clock phase-aligner DPS controller.
package gbt_rx_frameclk_phalgnr_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_PULSE = 3'd2,
        ST_WAIT  = 3'd3,
        ST_GAP   = 3'd4,
        ST_DONE  = 3'd5
    } dps_state_t;

    localparam logic [4:0] CNTSEL_C0 = 5'd0;

    // 720 MHz VCO / 8 gives one DPS step of ~173.6 ps; 144 of them fill a 25 ns period.
    localparam int STEPS_PER_PERIOD_40M = 144;
    localparam int DPS_STEP_PS          = 174;

    function automatic int pos_w(input int steps);
        return (steps <= 2) ? 1 : $clog2(steps);
    endfunction

    localparam int POS_W = pos_w(STEPS_PER_PERIOD_40M);

endpackage

// File: rtl/gbt_rx_frameclk_phalgnr_pos_cnt.sv
// Modulo-MODULUS up/down position counter with enable and synchronous clear.
module gbt_rx_frameclk_phalgnr_pos_cnt
    import gbt_rx_frameclk_phalgnr_pkg::*;
#(
    parameter int MODULUS = STEPS_PER_PERIOD_40M,
    parameter int W       = pos_w(MODULUS)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         en,
    input  logic         up,
    output logic [W-1:0] count
);

    localparam logic [W-1:0] MAX = W'(MODULUS - 1);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            count <= '0;
        end else if (en) begin
            if (up) begin
                count <= (count == MAX) ? '0 : count + 1'b1;
            end else begin
                count <= (count == '0) ? MAX : count - 1'b1;
            end
        end
    end

endmodule

// File: rtl/gbt_rx_frameclk_phalgnr_dps_ctrl.sv
// Drives the PLL dynamic-phase-shift handshake one step at a time and tracks phase position.
// Define GBT_RX_FRAMECLK_PHALGNR_DPS_TIMEOUT_EN to add a per-step phase_done timeout.
// Handshake: a request is accepted on a cycle where shift_req && ready; shift_dir and shift_steps are sampled then.
module gbt_rx_frameclk_phalgnr_dps_ctrl
  import gbt_rx_frameclk_phalgnr_pkg::*;
#(
  parameter int         STEP_CNT_W       = 8,
  parameter int         STEPS_PER_PERIOD = STEPS_PER_PERIOD_40M,
  parameter int         PHASE_EN_CYCLES  = 2,
  parameter logic [4:0] CNTSEL_C0        = gbt_rx_frameclk_phalgnr_pkg::CNTSEL_C0,
  parameter int         TIMEOUT_CYCLES   = 1024
) (
  input  logic                               scanclk,
  input  logic                               rst,
  input  logic                               pll_locked,
  input  logic                               shift_req,
  input  logic                               shift_dir,
  input  logic [STEP_CNT_W-1:0]              shift_steps,
  output logic                               ready,
  output logic                               busy,
  output logic                               done,
  output logic                               abort,
  output logic [pos_w(STEPS_PER_PERIOD)-1:0] position,
  output logic                               timeout,
  output logic                               phase_en,
  output logic                               updn,
  output logic [4:0]                         cntsel,
  input  logic                               phase_done,
  output logic [2:0]                         dbg_state
);

  localparam int PW = pos_w(STEPS_PER_PERIOD);

  dps_state_t            state;
  logic [STEP_CNT_W-1:0] remaining;
  logic                  ack_seen;
  logic [7:0]            pen_cnt;
  logic                  pos_en;

`ifdef GBT_RX_FRAMECLK_PHALGNR_DPS_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tmo_cnt;
`else
  assign timeout = 1'b0;
`endif

  // A step only counts once the PLL has acknowledged it while still locked.
  assign pos_en    = (state == ST_WAIT) && ack_seen && phase_done && pll_locked;
  assign dbg_state = state;

  gbt_rx_frameclk_phalgnr_pos_cnt #(
    .MODULUS (STEPS_PER_PERIOD),
    .W       (PW)
  ) u_pos_cnt (
    .clk   (scanclk),
    .rst   (rst),
    .clr   (!pll_locked),
    .en    (pos_en),
    .up    (updn),
    .count (position)
  );

  always_ff @(posedge scanclk) begin
    if (rst) begin
      state     <= ST_IDLE;
      remaining <= '0;
      ack_seen  <= 1'b0;
      pen_cnt   <= '0;
      phase_en  <= 1'b0;
      updn      <= 1'b0;
      cntsel    <= CNTSEL_C0;
      busy      <= 1'b0;
      done      <= 1'b0;
      abort     <= 1'b0;
      ready     <= 1'b0;
`ifdef GBT_RX_FRAMECLK_PHALGNR_DPS_TIMEOUT_EN
      tmo_cnt   <= '0;
      timeout   <= 1'b0;
`endif
    end else begin
      done  <= 1'b0;
      abort <= 1'b0;
      if (state != ST_IDLE && !pll_locked) begin
        state    <= ST_IDLE;
        phase_en <= 1'b0;
        busy     <= 1'b0;
        abort    <= 1'b1;
        ready    <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: begin
            ready <= pll_locked;
            if (shift_req && ready) begin
              updn      <= shift_dir;
              cntsel    <= CNTSEL_C0;
              remaining <= shift_steps;
              ready     <= 1'b0;
`ifdef GBT_RX_FRAMECLK_PHALGNR_DPS_TIMEOUT_EN
              timeout   <= 1'b0;
`endif
              if (shift_steps == '0) begin
                state <= ST_DONE;
                done  <= 1'b1;
              end else begin
                state <= ST_SETUP;
                busy  <= 1'b1;
              end
            end
          end
          ST_SETUP, ST_GAP: begin
            ack_seen <= 1'b0;
            pen_cnt  <= '0;
            phase_en <= 1'b1;
            state    <= ST_PULSE;
`ifdef GBT_RX_FRAMECLK_PHALGNR_DPS_TIMEOUT_EN
            tmo_cnt  <= '0;
`endif
          end
          ST_PULSE: begin
            if (!phase_done) ack_seen <= 1'b1;
            if (pen_cnt == 8'(PHASE_EN_CYCLES - 1)) begin
              phase_en <= 1'b0;
              state    <= ST_WAIT;
            end else begin
              pen_cnt <= pen_cnt + 1'b1;
            end
          end
          ST_WAIT: begin
            // phase_done must be seen low first so a stale high is not taken as the ack.
            if (!phase_done) ack_seen <= 1'b1;
            if (ack_seen && phase_done) begin
              remaining <= remaining - 1'b1;
              if (remaining == STEP_CNT_W'(1)) begin
                state <= ST_DONE;
                done  <= 1'b1;
                busy  <= 1'b0;
              end else begin
                state <= ST_GAP;
              end
            end
`ifdef GBT_RX_FRAMECLK_PHALGNR_DPS_TIMEOUT_EN
            else if (tmo_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
              state   <= ST_IDLE;
              busy    <= 1'b0;
              timeout <= 1'b1;
              ready   <= pll_locked;
            end else begin
              tmo_cnt <= tmo_cnt + 1'b1;
            end
`endif
          end
          ST_DONE: begin
            state <= ST_IDLE;
            ready <= pll_locked;
          end
          default: begin
            state <= ST_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_gbt_rx_frameclk_phalgnr_dps_ctrl.sv
// Bench for the RX frame-clock DPS controller; define GBT_RX_FRAMECLK_PHALGNR_DPS_TIMEOUT_EN to cover the timeout path.
module tb_gbt_rx_frameclk_phalgnr_dps_ctrl;

  localparam int PHASE_EN_CYCLES = 2;

  // clock / reset
  logic       scanclk = 1'b0;
  logic       rst = 1'b1;
  logic       pll_locked = 1'b0;
  logic       shift_req = 1'b0;
  logic       shift_dir = 1'b0;
  logic [7:0] shift_steps = 8'd0;
  logic       phase_done = 1'b1;
  logic       ready, busy, done, abort, timeout, phase_en, updn;
  logic [7:0] position;
  logic [4:0] cntsel;
  logic [2:0] dbg_state;

  always #5 scanclk = ~scanclk;

  gbt_rx_frameclk_phalgnr_dps_ctrl #(.TIMEOUT_CYCLES(16)) dut (
    .scanclk     (scanclk),
    .rst         (rst),
    .pll_locked  (pll_locked),
    .shift_req   (shift_req),
    .shift_dir   (shift_dir),
    .shift_steps (shift_steps),
    .ready       (ready),
    .busy        (busy),
    .done        (done),
    .abort       (abort),
    .position    (position),
    .timeout     (timeout),
    .phase_en    (phase_en),
    .updn        (updn),
    .cntsel      (cntsel),
    .phase_done  (phase_done),
    .dbg_state   (dbg_state)
  );

  int n_checks = 0;
  int n_fail = 0;
  logic [9:0] exp_q[$];
  int ev_cnt = 0;
  int pe_rises = 0;
  int pe_run = 0;
  logic pe_mon_prev = 1'b0;
  logic pulse_chk = 1'b1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // PLL phase_done model: low one cycle after phase_en rises, high again four cycles later.
  int   pd_t = -1;
  logic pe_prev = 1'b0;
  logic ack_en = 1'b1;
  always @(posedge scanclk) begin
    #1;
    if (phase_en && !pe_prev && ack_en) pd_t = 0;
    else if (pd_t >= 0) pd_t++;
    if (pd_t == 1) phase_done = 1'b0;
    if (pd_t == 5) begin
      phase_done = 1'b1;
      pd_t = -1;
    end
    pe_prev = phase_en;
  end

  // monitor: phase_en pulse shape and completion events against exp_q
  always @(negedge scanclk) begin
    logic [9:0] got;
    logic [9:0] exp;
    if (phase_en) begin
      pe_run++;
    end else begin
      if (pe_run != 0 && pulse_chk) check("phase_en_width", pe_run, PHASE_EN_CYCLES);
      pe_run = 0;
    end
    if (phase_en && !pe_mon_prev) pe_rises++;
    pe_mon_prev = phase_en;
    if (!rst && (done || abort)) begin
      got = {abort, done, position};
      if (exp_q.size() == 0) begin
        check("unexpected_event", got, 0);
      end else begin
        exp = exp_q.pop_front();
        check("event", got, exp);
      end
      ev_cnt++;
    end
  end

  task automatic do_shift(input logic dir, input logic [7:0] steps, input logic push,
                          input logic [9:0] exp_word);
    int n = 0;
    @(negedge scanclk);
    while (!ready && n < 50) begin
      @(negedge scanclk);
      n++;
    end
    check("ready_before_req", ready, 1);
    if (push) exp_q.push_back(exp_word);
    shift_req = 1'b1;
    shift_dir = dir;
    shift_steps = steps;
    @(posedge scanclk);
    #1;
    shift_req = 1'b0;
    check("ready_n1", ready, 0);
    check("busy_n1", busy, steps != 0);
    check("cntsel_n1", cntsel, 0);
    check("phase_en_n1", phase_en, 0);
    if (steps != 0) begin
      check("updn_n1", updn, dir);
      @(posedge scanclk);
      #1;
      check("phase_en_n2", phase_en, 1);
    end else begin
      check("done_n1", done, 1);
    end
  endtask

  task automatic wait_event(input int budget);
    int start = ev_cnt;
    int n = 0;
    while (ev_cnt == start && n < budget) begin
      @(negedge scanclk);
      #1;
      n++;
    end
    check("event_seen", ev_cnt != start, 1);
  endtask

  task automatic idle(input int cycles);
    repeat (cycles) @(negedge scanclk);
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int n;

    // reset with PLL unlocked
    repeat (4) @(posedge scanclk);
    #1;
    rst = 1'b0;
    @(negedge scanclk);
    check("rst_phase_en", phase_en, 0);
    check("rst_updn", updn, 0);
    check("rst_cntsel", cntsel, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_abort", abort, 0);
    check("rst_position", position, 0);
    check("rst_timeout", timeout, 0);
    check("rst_ready", ready, 0);
    check("rst_state", dbg_state, 0);

    @(posedge scanclk);
    #1;
    pll_locked = 1'b1;
    @(negedge scanclk);
    check("ready_lock_cycle", ready, 0);
    @(posedge scanclk);
    #1;
    check("ready_after_lock", ready, 1);

    // up 3 from 0
    base = pe_rises;
    do_shift(1'b1, 8'd3, 1'b1, {1'b0, 1'b1, 8'd3});
    wait_event(200);
    check("up3_pulses", pe_rises - base, 3);
    idle(10);

    // lock loss in WAIT of step 2 of 5
    base = pe_rises;
    do_shift(1'b1, 8'd5, 1'b1, {1'b1, 1'b0, 8'd0});
    n = 0;
    while (!((pe_rises - base) == 2 && dbg_state == 3'd3) && n < 200) begin
      @(negedge scanclk);
      #1;
      n++;
    end
    check("lockloss_reached_wait", n < 200, 1);
    pll_locked = 1'b0;
    @(posedge scanclk);
    #1;
    check("lockloss_phase_en", phase_en, 0);
    check("lockloss_abort", abort, 1);
    check("lockloss_done", done, 0);
    check("lockloss_state", dbg_state, 0);
    check("lockloss_position", position, 0);
    @(negedge scanclk);
    #1;
    pll_locked = 1'b1;
    check("ready_while_unlocked", ready, 0);
    @(posedge scanclk);
    #1;
    check("ready_after_relock", ready, 1);
    check("lockloss_pulses", pe_rises - base, 2);
    idle(10);

    // down wrap 0 -> 143
    base = pe_rises;
    do_shift(1'b0, 8'd1, 1'b1, {1'b0, 1'b1, 8'd143});
    wait_event(100);
    check("down_wrap_pulses", pe_rises - base, 1);
    idle(10);

    // up wrap 143 -> 0
    do_shift(1'b1, 8'd1, 1'b1, {1'b0, 1'b1, 8'd0});
    wait_event(100);
    idle(10);

    // zero steps: done at N+1, no phase_en
    base = pe_rises;
    do_shift(1'b1, 8'd0, 1'b1, {1'b0, 1'b1, 8'd0});
    wait_event(20);
    idle(5);
    check("zero_pulses", pe_rises - base, 0);
    idle(5);

    // max request: 255 steps up from 0 wraps to 111
    base = pe_rises;
    do_shift(1'b1, 8'd255, 1'b1, {1'b0, 1'b1, 8'd111});
    wait_event(3000);
    check("max_pulses", pe_rises - base, 255);
    idle(10);

    // down 2 from 111
    do_shift(1'b0, 8'd2, 1'b1, {1'b0, 1'b1, 8'd109});
    wait_event(100);
    idle(10);

`ifdef GBT_RX_FRAMECLK_PHALGNR_DPS_TIMEOUT_EN
    // phase_done never acknowledged: 16-cycle timeout
    ack_en = 1'b0;
    do_shift(1'b1, 8'd1, 1'b0, 10'd0);
    n = 0;
    while (dbg_state != 3'd3 && n < 20) begin
      @(negedge scanclk);
      #1;
      n++;
    end
    n = 0;
    while (!timeout && n < 100) begin
      @(negedge scanclk);
      #1;
      n++;
    end
    check("timeout_cycles", n, 16);
    check("timeout_state", dbg_state, 0);
    check("timeout_busy", busy, 0);
    check("timeout_position", position, 109);
    ack_en = 1'b1;
    idle(5);
    do_shift(1'b1, 8'd1, 1'b1, {1'b0, 1'b1, 8'd110});
    check("timeout_cleared", timeout, 0);
    wait_event(100);
    idle(10);
`endif

    // rst during a phase_en pulse
    do_shift(1'b1, 8'd3, 1'b0, 10'd0);
    pulse_chk = 1'b0;
    rst = 1'b1;
    @(posedge scanclk);
    #1;
    rst = 1'b0;
    check("midrst_phase_en", phase_en, 0);
    check("midrst_busy", busy, 0);
    check("midrst_state", dbg_state, 0);
    check("midrst_position", position, 0);
    idle(3);
    pulse_chk = 1'b1;
    check("midrst_ready", ready, 1);
    idle(20);

    check("queue_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/gbt_rx_frameclk_phalgnr_dps_ctrl.md
Name: gbt_rx_frameclk_phalgnr_dps_ctrl

Overview:
Dynamic-phase-shift (DPS) controller that drives the phase-shift interface of the RX frame-clock phase-aligner PLL (120 MHz ref -> 40 MHz outclk_0, 720 MHz VCO).
- Accepts "shift N steps up/down" requests from the phase-alignment logic.
- Sequences the phase_en / updn / cntsel handshake against phase_done, one step at a time.
- Tracks the resulting phase position modulo one 40 MHz period.
- Sits directly upstream of the PLL's DPS ports and runs in the PLL scanclk domain.

Parameters:
STEP_CNT_W, 8, width of requested step count
STEPS_PER_PERIOD, 144, DPS steps per outclk period (25 ns / 173.6 ps); position wraps here
PHASE_EN_CYCLES, 2, scanclk cycles phase_en is held high per step (min 2)
CNTSEL_C0, 5'd0, counter select driven on cntsel (outclk_0)
TIMEOUT_CYCLES, 1024, scanclk cycles to wait for phase_done per step (optional feature only)

Ports:
scanclk  in  1  clock, same scanclk fed to the PLL
rst  in  1  synchronous active-high reset
pll_locked  in  1  PLL locked status
shift_req  in  1  request; accepted when shift_req && ready
shift_dir  in  1  1 = up (updn=1), 0 = down; sampled on accept
shift_steps  in  STEP_CNT_W  step count; sampled on accept
ready  out  1  idle and PLL locked
busy  out  1  shift sequence in progress
done  out  1  one-cycle pulse, sequence completed
abort  out  1  one-cycle pulse, sequence aborted by lock loss
position  out  POS_W  phase offset in steps, 0..STEPS_PER_PERIOD-1 (POS_W = clog2(STEPS_PER_PERIOD))
timeout  out  1  sticky step timeout (optional feature; tied 0 otherwise)
phase_en  out  1  to PLL
updn  out  1  to PLL
cntsel  out  5  to PLL
phase_done  in  1  from PLL

Behaviour:
- Reset values: phase_en=0, updn=0, cntsel=CNTSEL_C0, busy=0, done=0, abort=0, position=0, timeout=0, state=IDLE.
- All outputs are registered. ready is registered as (state==IDLE && pll_locked).
- FSM states: IDLE, SETUP, PULSE, WAIT, GAP, DONE.
- IDLE:
  - Accept on cycle N (shift_req && ready): latch dir and steps into remaining.
  - steps==0 -> DONE (done high in cycle N+1, no phase_en).
  - steps!=0 -> SETUP.
  - shift_req while not ready is ignored, never queued.
- SETUP (1 cycle):
  - updn=dir and cntsel=CNTSEL_C0 are valid from cycle N+1 and held stable until the sequence ends.
  - Clears ack_seen -> PULSE.
- PULSE:
  - phase_en=1 for exactly PHASE_EN_CYCLES cycles (from N+2 for the first step) -> WAIT.
- ack_seen is set whenever phase_done is sampled 0 in PULSE or WAIT.
- WAIT:
  - phase_en=0. Exit when ack_seen && phase_done==1.
  - On exit: position += 1 (up) or -= 1 (down), modulo STEPS_PER_PERIOD (143+1 -> 0; 0-1 -> 143). remaining -= 1.
  - remaining==0 -> DONE, else -> GAP.
- GAP (1 cycle, phase_en=0): clears ack_seen -> PULSE.
- DONE: done=1 for one cycle, busy=0 -> IDLE.
- busy=1 in SETUP, PULSE, WAIT and GAP.
- Lock loss (pll_locked==0 in any non-IDLE state):
  - Next cycle: phase_en=0, abort=1 for one cycle, state=IDLE.
  - No done pulse, and the position increment for the in-flight step is discarded.
- position clears to 0 whenever pll_locked==0, because the PLL relocks at zero offset.
- rst mid-sequence: all state returns to reset values next cycle; phase_en drops immediately.
- A max request of 255 steps exceeds one period, and position wraps correctly.

Optional Feature:
- Macro: GBT_RX_FRAMECLK_PHALGNR_DPS_TIMEOUT_EN.
- With the macro:
  - A per-step counter runs in WAIT and clears on entry to PULSE.
  - On reaching TIMEOUT_CYCLES it forces phase_en=0 and state=IDLE, with no done or abort pulse.
  - timeout is set sticky; it clears on rst or on the next accepted request.
- Without the macro: WAIT waits indefinitely (lock loss is the only escape), timeout is tied 0, and no counter logic exists.

Decomposition:
- Package gbt_rx_frameclk_phalgnr_pkg holds: FSM state enum, CNTSEL_C0 constant, STEPS_PER_PERIOD_40M=144, DPS_STEP_PS=174 constant, POS_W function/localparam.
- One sub-module: gbt_rx_frameclk_phalgnr_pos_cnt, a modulo-STEPS_PER_PERIOD up/down counter with enable, dir and sync clear.

Test Plan:
- Reset/lock:
  - Stimulus: rst high 4 cycles; pll_locked=0, then 1.
  - Response: all outputs at reset values; ready=0 until the cycle after pll_locked=1.
- Up shift:
  - Stimulus: req dir=1 steps=3; PLL model drives phase_done low 1 cycle after phase_en rises, high 4 cycles later.
  - Response: updn=1 and cntsel=0 from N+1; three 2-cycle phase_en pulses separated by ≥1 low cycle; single done pulse; position=3.
- Down wrap:
  - Stimulus: from position=0, req dir=0 steps=1.
  - Response: one phase_en pulse, updn=0, position=143, done.
- Zero steps:
  - Stimulus: req steps=0.
  - Response: done in cycle N+1; phase_en never high; position unchanged.
- Lock loss:
  - Stimulus: drop pll_locked during WAIT of step 2 of 5.
  - Response: next cycle phase_en=0 and abort=1; no done; position=0; ready returns after relock.
- Timeout (macro on, TIMEOUT_CYCLES=16):
  - Stimulus: model never drives phase_done low.
  - Response: 16 cycles into WAIT, timeout=1 and state=IDLE; timeout clears on the next accepted request.
